// File: rtl/ovl_unchange_multi.sv
// ovl_unchange_multi
// Multi-lane "unchange" checker. Each lane opens a window on start_event,
// captures its slice of test_expr as a reference and, for the next num_cks
// sampling edges, flags any sample that differs from that reference. All
// outputs are registered. err_count accumulates every fire pulse from every
// lane and saturates at 16'hFFFF.
//
// Optional feature: define OVL_UNCHANGE_XCHECK_EN to compile the X/Z checks
// that drive fire_xz. With the macro undefined, fire_xz is tied to 0.
//
// Ports
//   clk             sampling clock, rising edge
//   reset_n         asynchronous active-low reset
//   start_event     [channels]        per-lane window start
//   test_expr       [channels*width]  lane k at [k*width +: width]
//   window          [channels]        lane window open (this is the lane FSM state)
//   fire_unchange   [channels]        value changed inside the window
//   fire_new_start  [channels]        start while open (mode 2 only)
//   fire_xz         [channels]        X/Z seen on start or on test_expr while open
//   window_close    [channels]        window closed normally
//   err_count       [16]              saturating count of all fire pulses
//
// Handshake: there is none. start_event is a level sampled on every rising
// edge; every output is a registered pulse or level with no back-pressure.
module ovl_unchange_multi #(
  parameter int channels            = 4,
  parameter int width               = 8,
  parameter int num_cks             = 4,
  parameter int action_on_new_start = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [channels-1:0]         start_event,
  input  logic [channels*width-1:0]   test_expr,
  output logic [channels-1:0]         window,
  output logic [channels-1:0]         fire_unchange,
  output logic [channels-1:0]         fire_new_start,
  output logic [channels-1:0]         fire_xz,
  output logic [channels-1:0]         window_close,
  output logic [15:0]                 err_count
);

  localparam int CW = $clog2(num_cks + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  if (action_on_new_start < 0 || action_on_new_start > 2) begin : g_bad_mode
    $error("ovl_unchange_multi: action_on_new_start must be 0, 1 or 2");
  end

  // Next-cycle fire bits of every lane, used to update err_count in the same
  // cycle the registered fires become visible.
  logic [channels-1:0] fu_d;
  logic [channels-1:0] fn_d;
  logic [channels-1:0] fx_d;

  for (genvar k = 0; k < channels; k++) begin : g_lane
    logic [width-1:0] cur;
    logic             start;
    logic [0:0]       st_q, st_d;
    logic [width-1:0] ref_q, ref_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fu, fn, fx, wc;
    logic             start_x, expr_x;
    logic             fu_q, fn_q, fx_q, wc_q;

    assign cur   = test_expr[k*width +: width];
    assign start = start_event[k];

    always_comb begin
      st_d    = st_q;
      ref_d   = ref_q;
      cnt_d   = cnt_q;
      fu      = 1'b0;
      fn      = 1'b0;
      wc      = 1'b0;
      start_x = 1'b0;
      expr_x  = 1'b0;
`ifdef OVL_UNCHANGE_XCHECK_EN
      start_x = $isunknown(start);
      expr_x  = (st_q == ST_OPEN) && $isunknown(cur);
`endif
      // An unknown start freezes the lane for this cycle.
      if (!start_x) begin
        if (st_q == ST_IDLE) begin
          if (start) begin
            ref_d = cur;
            cnt_d = CW'(num_cks);
            st_d  = ST_OPEN;
          end
        end else if (start && action_on_new_start == 1) begin
          // Restart cycle: re-capture and re-arm, no comparison, no close.
          ref_d = cur;
          cnt_d = CW'(num_cks);
        end else begin
          // An X compare evaluates false, so unknown values never fire here.
          if (!expr_x && (cur != ref_q)) fu = 1'b1;
          if (start && action_on_new_start == 2) fn = 1'b1;
          if (cnt_q == CW'(1)) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
            wc    = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      fx = start_x || expr_x;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= ST_IDLE;
        ref_q <= '0;
        cnt_q <= '0;
        fu_q  <= 1'b0;
        fn_q  <= 1'b0;
        fx_q  <= 1'b0;
        wc_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        ref_q <= ref_d;
        cnt_q <= cnt_d;
        fu_q  <= fu;
        fn_q  <= fn;
        fx_q  <= fx;
        wc_q  <= wc;
      end
    end

    assign window[k]         = (st_q == ST_OPEN);
    assign fire_unchange[k]  = fu_q;
    assign fire_new_start[k] = fn_q;
    assign window_close[k]   = wc_q;
`ifdef OVL_UNCHANGE_XCHECK_EN
    assign fire_xz[k]        = fx_q;
`else
    assign fire_xz[k]        = 1'b0;
`endif
    assign fu_d[k] = fu;
    assign fn_d[k] = fn;
`ifdef OVL_UNCHANGE_XCHECK_EN
    assign fx_d[k] = fx;
`else
    assign fx_d[k] = 1'b0;
`endif
  end

  logic [16:0] inc;
  logic [16:0] sum;

  always_comb begin
    inc = '0;
    for (int i = 0; i < channels; i++) begin
      inc = inc + 17'(fu_d[i]) + 17'(fn_d[i]) + 17'(fx_d[i]);
    end
    sum = {1'b0, err_count} + inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else begin
      err_count <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

endmodule
